// File: rtl/ruleta_freno.sv
// ruleta_freno: spin/brake controller for the roulette stage.
//
// A start-button press makes the block issue one-cycle step pulses in the
// clk16 domain. The pulses slow down through four rates: every cycle, then
// every 2, every 4 and every 8 cycles. After the last pulse the block stops
// and holds done. A free-running mod-6 seed is latched at the press and adds
// 0..5 extra fast steps, so the landing position changes from press to press.
//
// Ports:
//   clk16     in   16 Hz system clock
//   reset     in   asynchronous, active-high reset
//   start_btn in   raw start button (asynchronous to clk16), active-high
//   step      out  one-cycle advance pulse for the roulette
//   spinning  out  high in FAST, MED, SLOW and CRAWL
//   done      out  high in DONE
//   phase     out  0 IDLE, 1 FAST, 2 MED, 3 SLOW, 4 CRAWL, 5 DONE
module ruleta_freno #(
  parameter int STEPS_16 = 24,
  parameter int STEPS_8  = 12,
  parameter int STEPS_4  = 6,
  parameter int STEPS_2  = 3
) (
  input  logic       clk16,
  input  logic       reset,
  input  logic       start_btn,
  output logic       step,
  output logic       spinning,
  output logic       done,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FAST  = 3'd1,
    MED   = 3'd2,
    SLOW  = 3'd3,
    CRAWL = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] LEN_16 = 6'(STEPS_16);
  localparam logic [5:0] LEN_8  = 6'(STEPS_8);
  localparam logic [5:0] LEN_4  = 6'(STEPS_4);
  localparam logic [5:0] LEN_2  = 6'(STEPS_2);

  state_t     state, state_nxt, follow;
  logic       s1, s2, s2_d;
  logic       start_pulse;
  logic [2:0] seed;
  logic [2:0] extra, extra_nxt;
  logic [2:0] div_cnt, div_nxt, div_last;
  logic [5:0] stp_cnt, stp_nxt, len;
  logic       last_step;

  // Button synchronizer plus edge detector: one pulse per press, however long
  // the button is held.
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= start_btn;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign start_pulse = s2 & ~s2_d;

  // Seed runs in every state so the press instant picks the extra steps.
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) seed <= 3'd0;
    else       seed <= (seed == 3'd5) ? 3'd0 : seed + 3'd1;
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      extra   <= 3'd0;
      div_cnt <= 3'd0;
      stp_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      extra   <= extra_nxt;
      div_cnt <= div_nxt;
      stp_cnt <= stp_nxt;
    end
  end

  always_comb begin
    div_last  = 3'd0;
    len       = 6'd1;
    follow    = IDLE;
    spinning  = 1'b0;
    done      = 1'b0;
    state_nxt = state;
    extra_nxt = extra;
    div_nxt   = div_cnt;
    stp_nxt   = stp_cnt;

    // Per-phase divisor (as terminal count), length and successor.
    case (state)
      FAST:  begin div_last = 3'd0; len = LEN_16 + {3'b000, extra}; follow = MED;   spinning = 1'b1; end
      MED:   begin div_last = 3'd1; len = LEN_8;                    follow = SLOW;  spinning = 1'b1; end
      SLOW:  begin div_last = 3'd3; len = LEN_4;                    follow = CRAWL; spinning = 1'b1; end
      CRAWL: begin div_last = 3'd7; len = LEN_2;                    follow = DONE;  spinning = 1'b1; end
      DONE:  done = 1'b1;
      default: ;
    endcase

    step      = spinning && (div_cnt == div_last);
    last_step = step && (stp_cnt == len - 6'd1);

    if (!spinning) begin
      // Presses are only honoured when idle or finished.
      if ((state == IDLE || state == DONE) && start_pulse) begin
        state_nxt = FAST;
        extra_nxt = seed;
        div_nxt   = 3'd0;
        stp_nxt   = 6'd0;
      end
    end else if (last_step) begin
      state_nxt = follow;
      div_nxt   = 3'd0;
      stp_nxt   = 6'd0;
    end else if (step) begin
      div_nxt = 3'd0;
      stp_nxt = stp_cnt + 6'd1;
    end else begin
      div_nxt = div_cnt + 3'd1;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_ruleta_freno.sv
// Directed bench for ruleta_freno: reset/idle, spins with chosen extra values,
// presses during a spin, held button, reset mid-spin, restart from DONE and a
// glitch shorter than a clock period.
module tb_ruleta_freno;

  logic       clk16;
  logic       reset;
  logic       start_btn;
  logic       step;
  logic       spinning;
  logic       done;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int edge_n;
  int wheel = 0;

  ruleta_freno dut (
    .clk16     (clk16),
    .reset     (reset),
    .start_btn (start_btn),
    .step      (step),
    .spinning  (spinning),
    .done      (done),
    .phase     (phase)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  // Clock edges since reset release; the seed should equal this mod 6.
  always @(posedge clk16 or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk16);
  endtask

  // Expected phase/step for cycle i of a spin (i=0 is the first FAST cycle).
  function automatic void exp_at(input int i, input int e, output int ph, output int st);
    int j;
    j = i;
    if (j < 24 + e) begin ph = 1; st = 1; return; end
    j -= 24 + e;
    if (j < 24) begin ph = 2; st = (j % 2 == 1) ? 1 : 0; return; end
    j -= 24;
    if (j < 24) begin ph = 3; st = (j % 4 == 3) ? 1 : 0; return; end
    j -= 24;
    if (j < 24) begin ph = 4; st = (j % 8 == 7) ? 1 : 0; return; end
    ph = 5; st = 0;
  endfunction

  // Press so that the latched extra equals e; returns at the first FAST cycle.
  task automatic press(input int e);
    start_btn = 1'b0;
    tick(3);
    while (((edge_n + 2) % 6) != e) tick(1);
    start_btn = 1'b1;
    tick(3);
  endtask

  // mode 0: release button; mode 1: extra presses in MED, CRAWL and the last
  // CRAWL cycle; mode 2: button stays held throughout.
  task automatic check_spin(input string tag, input int e, input int mode);
    int ph, st, nsteps, last, f, c;
    nsteps = 0;
    last   = 96 + e;
    f      = 24 + e;
    c      = f + 48;
    for (int i = 0; i <= last; i++) begin
      exp_at(i, e, ph, st);
      chk({tag, "_phase"}, 32'(phase), 32'(ph));
      chk({tag, "_step"}, 32'(step), 32'(st));
      chk({tag, "_spinning"}, 32'(spinning), 32'((ph >= 1 && ph <= 4) ? 1 : 0));
      chk({tag, "_done"}, 32'(done), 32'((ph == 5) ? 1 : 0));
      if (step === 1'b1) begin
        nsteps++;
        wheel = (wheel + 1) % 6;
      end
      if (mode == 0 && i == 0) start_btn = 1'b0;
      if (mode == 1) begin
        if (i == 0)      start_btn = 1'b0;
        if (i == f + 3)  start_btn = 1'b1;
        if (i == f + 8)  start_btn = 1'b0;
        if (i == c + 2)  start_btn = 1'b1;
        if (i == c + 5)  start_btn = 1'b0;
        if (i == 93 + e) start_btn = 1'b1;
      end
      if (i < last) tick(1);
    end
    chk({tag, "_count"}, 32'(nsteps), 32'(45 + e));
  endtask

  initial begin
    reset     = 1'b1;
    start_btn = 1'b0;
    #1;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_spinning", 32'(spinning), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_seed", 32'(dut.seed), 32'd0);
    tick(2);
    reset = 1'b0;
    wheel = 0;

    // Idle: nothing moves, seed counts 0..5.
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      chk("idle_phase", 32'(phase), 32'd0);
      chk("idle_step", 32'(step), 32'd0);
      chk("idle_seed", 32'(dut.seed), 32'(i % 6));
    end

    // Sub-period glitch between clock edges is never sampled.
    start_btn = 1'b1;
    #2;
    start_btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("glitch_phase", 32'(phase), 32'd0);
    end

    // Spin with extra = 2: 98 cycles, lands on 5.
    press(2);
    check_spin("spin_e2", 2, 0);
    chk("landing_e2", 32'(wheel), 32'd5);
    tick(5);
    chk("done_hold", 32'(done), 32'd1);

    // Restart from DONE with extra = 5, stray presses during the spin.
    press(5);
    check_spin("spin_e5", 5, 1);
    start_btn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("after_press_done", 32'(done), 32'd1);
      chk("after_press_step", 32'(step), 32'd0);
    end

    // Button held for ~200 cycles: exactly one spin.
    press(0);
    check_spin("held_e0", 0, 2);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("held_done", 32'(done), 32'd1);
      chk("held_step", 32'(step), 32'd0);
    end
    start_btn = 1'b0;

    // Reset in the middle of SLOW, right while a step is showing.
    press(1);
    start_btn = 1'b0;
    tick(52);
    chk("mid_slow_phase", 32'(phase), 32'd3);
    chk("mid_slow_step", 32'(step), 32'd1);
    #2;
    reset = 1'b1;
    wheel = 0;
    #1;
    chk("async_rst_step", 32'(step), 32'd0);
    chk("async_rst_spinning", 32'(spinning), 32'd0);
    chk("async_rst_phase", 32'(phase), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("post_rst_phase", 32'(phase), 32'd0);

    // Fresh full spin after reset with extra = 4.
    press(4);
    check_spin("fresh_e4", 4, 0);
    chk("landing_e4", 32'(wheel), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
